// File: rtl/cop_instr_issuer.sv
// Host-side instruction issuer for the matrix coprocessor: buffers host commands,
// packs them into 32-bit instruction words and issues them one at a time.
module cop_instr_issuer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    input  logic        flush,
    output logic [31:0] instruction,
    output logic        activate_instruction,
    input  logic        cop_done,
    input  logic [15:0] cop_data,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        err_timeout,
    output logic [15:0] issued_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    OP_READ  = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Entry layout matches instruction[27:0]: {data, addr, opcode}
    logic [27:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          push_s, pop_s, empty_s;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   instruction_q, instruction_d;
    logic          activate_q, activate_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [15:0]   issued_q, issued_d;
    logic          cop_done_q;
    logic          done_rise_s;

    assign empty_s     = (count_q == {CW{1'b0}});
    assign push_s      = cmd_valid & cmd_ready_q & ~flush;
    assign pop_s       = (state_q == ST_IDLE) & ~empty_s;
    assign done_rise_s = cop_done & ~cop_done_q;

    // FIFO pointer/count next-state; flush wins over a same-cycle push
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        cmd_ready_d = (count_d != FULL_CNT);
    end

    // Issue FSM next-state and registered output values
    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        instruction_d = instruction_q;
        activate_d    = 1'b0;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        err_d         = err_q;
        issued_d      = issued_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_d       = ST_ISSUE;
                    instruction_d = {4'b0000, fifo_mem[rd_ptr_q]};
                    activate_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = {TW{1'b0}};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the timeout cycle still counts as success
                if (done_rise_s) begin
                    issued_d = issued_q + 16'd1;
                    state_d  = ST_GAP;
                    if (instruction_q[3:0] == OP_READ) begin
                        rd_data_d  = cop_data;
                        rd_valid_d = 1'b1;
                    end else begin
                        rd_data_d  = rd_data_q;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE) | (count_d != {CW{1'b0}});
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q] <= {cmd_data, cmd_addr, cmd_opcode};
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            count_q       <= {CW{1'b0}};
            cmd_ready_q   <= 1'b0;
            state_q       <= ST_IDLE;
            tmo_q         <= {TW{1'b0}};
            instruction_q <= 32'd0;
            activate_q    <= 1'b0;
            rd_data_q     <= 16'd0;
            rd_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            issued_q      <= 16'd0;
            cop_done_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cmd_ready_q   <= cmd_ready_d;
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            instruction_q <= instruction_d;
            activate_q    <= activate_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            issued_q      <= issued_d;
            cop_done_q    <= cop_done;
        end
    end

    assign cmd_ready            = cmd_ready_q;
    assign instruction          = instruction_q;
    assign activate_instruction = activate_q;
    assign rd_data              = rd_data_q;
    assign rd_valid             = rd_valid_q;
    assign busy                 = busy_q;
    assign err_timeout          = err_q;
    assign issued_cnt           = issued_q;

endmodule

// File: tb/tb_cop_instr_issuer.sv
// Directed bench for cop_instr_issuer: expected instruction words are queued on
// push and popped when the issue strobe appears.
module tb_cop_instr_issuer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        flush;
    logic [31:0] instruction;
    logic        activate_instruction;
    logic        cop_done;
    logic [15:0] cop_data;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        err_timeout;
    logic [15:0] issued_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cyc = 0;
    int exp_issued = 0;
    logic [31:0] exp_q[$];

    cop_instr_issuer #(.DEPTH(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .flush(flush),
        .instruction(instruction), .activate_instruction(activate_instruction),
        .cop_done(cop_done), .cop_data(cop_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .err_timeout(err_timeout), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pack(input logic [3:0] op, input logic [7:0] a, input logic [15:0] d);
        return {4'b0000, d, a, op};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [15:0] d, input logic acc);
        cmd_opcode = op;
        cmd_addr   = a;
        cmd_data   = d;
        cmd_valid  = 1'b1;
        check("cmd_ready", 32'(cmd_ready), 32'(acc));
        if (acc) exp_q.push_back(pack(op, a, d));
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_strobe(input string tag, input int max_cyc, output int waited);
        logic found;
        found  = 1'b0;
        waited = 0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            @(negedge clk);
            waited = i + 1;
            if (activate_instruction) found = 1'b1;
        end
        check({tag, "_strobe"}, 32'(found), 32'd1);
        if (found) begin
            strobe_cyc = cyc;
            if (exp_q.size() == 0) check({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
            else check({tag, "_instr"}, instruction, exp_q.pop_front());
        end
    endtask

    // Raise cop_done k negedges from now; returns one negedge after detection
    task automatic complete_after(input int k);
        tick(k);
        cop_done = 1'b1;
        tick(1);
        cop_done = 1'b0;
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (activate_instruction) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
        check({tag, "_instr"}, instruction, 32'd0);
        check({tag, "_act"}, 32'(activate_instruction), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err_timeout), 32'd0);
        check({tag, "_issued"}, 32'(issued_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, t0, t1;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_addr = 8'd0;
        cmd_data = 16'd0; flush = 1'b0; cop_done = 1'b0; cop_data = 16'd0;
        tick(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        tick(1);
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        // WRITE: packing, 1-cycle latency, single-cycle strobe, completion
        push(4'd2, 8'h05, 16'h1234, 1'b1);
        wait_strobe("write1", 5, w);
        check("write1_latency", 32'(w), 32'd1);
        check("write1_pack", instruction, 32'h01234052);
        tick(1);
        check("write1_strobe_len", 32'(activate_instruction), 32'd0);
        check("write1_hold", instruction, 32'h01234052);
        complete_after(2);
        exp_issued++;
        check("write1_issued", 32'(issued_cnt), 32'(exp_issued));
        check("write1_no_rdvalid", 32'(rd_valid), 32'd0);
        tick(1);
        check("write1_idle_busy", 32'(busy), 32'd0);

        // READ captures cop_data with a one-cycle rd_valid
        cop_data = 16'hBEEF;
        push(4'd1, 8'h15, 16'h0000, 1'b1);
        wait_strobe("read1", 5, w);
        complete_after(1);
        exp_issued++;
        check("read1_rd_valid", 32'(rd_valid), 32'd1);
        check("read1_rd_data", 32'(rd_data), 32'h0000BEEF);
        check("read1_issued", 32'(issued_cnt), 32'(exp_issued));
        tick(1);
        check("read1_rd_valid_pulse", 32'(rd_valid), 32'd0);
        check("read1_rd_data_hold", 32'(rd_data), 32'h0000BEEF);

        // Completion in the very cycle the timeout would fire: done wins
        push(4'd2, 8'h22, 16'h0F0F, 1'b1);
        wait_strobe("edge", 5, w);
        complete_after(16);
        exp_issued++;
        check("edge_issued", 32'(issued_cnt), 32'(exp_issued));
        check("edge_no_err", 32'(err_timeout), 32'd0);
        tick(2);

        // Fill: one in flight plus 8 queued, the 9th push is refused
        push(4'd2, 8'h30, 16'h5555, 1'b1);
        wait_strobe("fill_head", 5, w);
        for (int k = 0; k < 9; k++) push(4'd2, 8'(8'h40 + k), 16'(16'hA000 + k), k < 8);
        check("full_ready", 32'(cmd_ready), 32'd0);

        // The in-flight head times out after 16 WAIT cycles
        tick(7);
        check("tmo_not_yet", 32'(err_timeout), 32'd0);
        tick(1);
        check("tmo_err", 32'(err_timeout), 32'd1);
        check("tmo_issued", 32'(issued_cnt), 32'(exp_issued));
        check("tmo_busy", 32'(busy), 32'd1);
        wait_strobe("after_tmo", 5, w);
        check("after_tmo_gap", 32'(w), 32'd2);
        for (int k = 0; k < 3; k++) wait_strobe("drain", 40, w);
        check("drain_issued", 32'(issued_cnt), 32'(exp_issued));

        // Flush with 4 queued while one is in flight; a same-cycle push is dropped
        cmd_opcode = 4'd3; cmd_addr = 8'h77; cmd_data = 16'h7777;
        cmd_valid = 1'b1;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        cmd_valid = 1'b0;
        exp_q.delete();
        check("flush_busy", 32'(busy), 32'd1);
        complete_after(2);
        exp_issued++;
        check("flush_inflight_done", 32'(issued_cnt), 32'(exp_issued));
        tick(1);
        check("flush_idle", 32'(busy), 32'd0);
        check("flush_ready", 32'(cmd_ready), 32'd1);
        expect_quiet("flush_quiet", 30);

        // SUM, DET3, READ queued behind an in-flight WRITE
        push(4'd2, 8'h01, 16'h0001, 1'b1);
        wait_strobe("dummy", 5, w);
        push(4'd3, 8'h10, 16'h0003, 1'b1);
        push(4'd10, 8'h20, 16'h000A, 1'b1);
        push(4'd1, 8'h30, 16'h0000, 1'b1);
        complete_after(1);
        exp_issued++;
        wait_strobe("sum", 10, w);
        check("sum_op", 32'(instruction[3:0]), 32'd3);
        t0 = strobe_cyc;
        complete_after(4);
        wait_strobe("det3", 10, w);
        check("det3_op", 32'(instruction[3:0]), 32'd10);
        t1 = strobe_cyc;
        check("det3_spacing", 32'(t1 - t0 >= 7), 32'd1);
        complete_after(4);
        wait_strobe("read2", 10, w);
        check("read2_op", 32'(instruction[3:0]), 32'd1);
        check("read2_spacing", 32'(strobe_cyc - t1 >= 7), 32'd1);
        cop_data = 16'h5A5A;
        complete_after(4);
        exp_issued += 3;
        check("read2_rd_data", 32'(rd_data), 32'h00005A5A);
        check("read2_rd_valid", 32'(rd_valid), 32'd1);
        check("seq_issued", 32'(issued_cnt), 32'(exp_issued));
        check("err_sticky", 32'(err_timeout), 32'd1);
        tick(2);

        // Asynchronous reset during WAIT with one entry still queued
        push(4'd2, 8'h0A, 16'hCAFE, 1'b1);
        wait_strobe("pre_rst", 5, w);
        push(4'd2, 8'h0B, 16'hBABE, 1'b1);
        tick(1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        tick(1);
        cop_done = 1'b1;
        tick(2);
        check("rst_done_ignored", 32'(issued_cnt), 32'd0);
        cop_done = 1'b0;
        expect_quiet("rst_fifo_lost", 10);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cop_instr_issuer.md
Name: cop_instr_issuer

Overview:
- Host-side instruction issuer for the matrix coprocessor. It drives the coprocessor's `instruction` / `activate_instruction` inputs.
- Buffers host commands (opcode, address, data) in a small FIFO and packs each one into the 32-bit instruction word.
- Issues one instruction at a time, waits for the coprocessor's completion signal, captures READ results and flags timeouts.
- Sits between the host bus glue and the coprocessor top level.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TIMEOUT, 4096, max cycles in WAIT before the issue is abandoned; minimum 2.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  FIFO can accept a command
- cmd_opcode  in  4  coprocessor opcode (READ=1, WRITE=2, SUM=3 … DET5=12)
- cmd_addr  in  8  matrix element address
- cmd_data  in  16  write data / scalar operand
- flush  in  1  synchronous FIFO clear
- instruction  out  32  packed instruction to the coprocessor
- activate_instruction  out  1  one-cycle issue strobe
- cop_done  in  1  coprocessor completion level
- cop_data  in  16  coprocessor memory read data
- rd_data  out  16  captured READ result
- rd_valid  out  1  one-cycle pulse when rd_data updates
- busy  out  1  FIFO non-empty or FSM not IDLE
- err_timeout  out  1  sticky timeout flag
- issued_cnt  out  16  completed-instruction counter

Behaviour:
- Reset (async, reset_n=0): all outputs 0; FIFO empty; FSM in IDLE; done-edge register 0.
- Instruction packing:
  - [3:0] = opcode
  - [11:4] = addr
  - [27:12] = data
  - [31:28] = 0
- FIFO:
  - Push when cmd_valid & cmd_ready.
  - cmd_ready = !full. Full refuses a push even if a pop happens in the same cycle.
  - Pop only in IDLE→ISSUE.
  - Pointers wrap modulo DEPTH; a count register distinguishes full from empty.
- Flush:
  - Empties the FIFO next cycle.
  - Does not abort an in-flight instruction.
  - A push in the same cycle as flush is dropped.
- Done edge: done_rise = cop_done & !cop_done_q, where cop_done_q is registered every cycle.
- FSM states:
  - IDLE:
    - FIFO non-empty → ISSUE.
    - Pop the head and register instruction from it on the transition.
  - ISSUE:
    - activate_instruction=1 for exactly this one cycle.
    - Clear the timeout counter → WAIT.
  - WAIT:
    - activate_instruction=0; instruction holds its value.
    - done_rise → GAP; issued_cnt += 1, wrapping at 16 bits.
    - If the opcode is READ, rd_data ← cop_data and rd_valid=1 for the next cycle.
    - Otherwise the counter increments. At counter == TIMEOUT-1 with no done_rise → err_timeout=1 and go to GAP; issued_cnt is unchanged.
    - done_rise and the timeout in the same cycle: done wins, no error.
  - GAP: one idle cycle so the coprocessor can return to FETCH → IDLE.
- Latency: FIFO non-empty in IDLE at cycle N → activate_instruction high at N+1. The minimum back-to-back issue spacing is 1 (ISSUE) + WAIT duration + 1 (GAP).
- done_rise observed in IDLE, ISSUE or GAP is ignored.
- err_timeout clears only on reset.
- busy = (FSM != IDLE) | !empty.
- Reset mid-operation returns everything to the reset state immediately; the FIFO contents are lost.

Test Plan:
- Reset, then push WRITE (op=2, addr=0x05, data=0x1234) → instruction=0x01234052; activate_instruction high exactly 1 cycle, 1 cycle after IDLE sees the entry. Pulse cop_done 3 cycles later → issued_cnt=1, busy=0 after GAP.
- READ (op=1, addr=0x15) with cop_data=0xBEEF and cop_done rising → rd_data=0xBEEF, rd_valid high 1 cycle; a WRITE completion leaves rd_valid=0.
- Push 9 commands with DEPTH=8 and cop_done held low → cmd_ready=0 after the 8th accepted push (one entry already popped into flight); refused pushes are not stored.
- TIMEOUT=16, cop_done never rises → err_timeout=1 after 16 WAIT cycles; issued_cnt unchanged; the next FIFO entry is issued after GAP; err_timeout stays 1.
- Three queued commands (SUM, DET3, READ), each completed 5 cycles after its strobe → three strobes, each separated by ≥7 cycles; issued_cnt=3; instruction opcodes 3, 10, 1 in order.
- flush with 4 entries queued while one is in WAIT → FIFO empty next cycle; the in-flight instruction still completes (issued_cnt+1); no further strobes.
- reset_n low during WAIT → all outputs 0 asynchronously; after release, cop_done rising does not increment issued_cnt.
